dmem_wait: RTL

Parametrised data-memory block for the MIPS core: a synchronous word-organised RAM behind a request/acknowledge handshake, with per-byte write enables and a programmable number of wait states. It replaces the single-cycle data memory on the core's data port so that the pipeline's stall logic can be exercised against slow memory. Depth, data width and latency are set per instance.

---
 rtl/dmem_wait_if.sv | 34 +++
 rtl/dmem_wait.sv | 112 +++++++++++
 2 files changed

// File: rtl/dmem_wait_if.sv
// Request/acknowledge bus between the core's data port and dmem_wait.
// The err signal exists only when DMEM_ERR_EN is defined.
interface dmem_wait_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic              req;
    logic              wr;
    logic [AW-1:0]     addr;
    logic [DW/8-1:0]   be;
    logic [DW-1:0]     din;
    logic [DW-1:0]     dout;
    logic              ack;
    logic              busy;
`ifdef DMEM_ERR_EN
    logic              err;
`endif

    modport master (
        output req, wr, addr, be, din,
        input  dout, ack, busy
`ifdef DMEM_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  req, wr, addr, be, din,
        output dout, ack, busy
`ifdef DMEM_ERR_EN
        , output err
`endif
    );
endinterface

// File: rtl/dmem_wait.sv
// Word RAM behind a req/ack handshake with byte enables and WAIT wait states per access.
// Optional DMEM_ERR_EN: out-of-range addresses (>= DEPTH) are suppressed and flagged on err.
module dmem_wait #(
    parameter int AW    = 6,
    parameter int DW    = 32,
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input logic        clk,
    input logic        rst_n,
    dmem_wait_if.slave bus
);
    localparam int NB = DW / 8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            wr_q;
    logic [AW-1:0]   addr_q;
    logic [NB-1:0]   be_q;
    logic [DW-1:0]   din_q;
    logic [DW-1:0]   dout_q;
    logic            ack_q;
    logic            busy_q;

    logic [AW-1:0]   idx;
    logic            in_range;
    logic            do_access;
    logic            mem_we;
    logic [DW-1:0]   mem [DEPTH];

    assign idx = AW'(int'(addr_q) % DEPTH);

`ifdef DMEM_ERR_EN
    logic err_q;
    assign in_range = int'(addr_q) < DEPTH;
    assign bus.err  = err_q;
`else
    assign in_range = 1'b1;
`endif

    // The access edge is the last WAIT cycle; a reset before it leaves state IDLE, dropping the write.
    assign do_access = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mem_we    = do_access && wr_q && in_range;

    // NOTE: the array has no reset branch so it maps onto RAM macros; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) mem[idx][8*i +: 8] <= din_q[8*i +: 8];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DMEM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        wr_q    <= bus.wr;
                        addr_q  <= bus.addr;
                        be_q    <= bus.be;
                        din_q   <= bus.din;
                        cnt_q   <= 4'(WAIT);
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_RESP;
                        ack_q   <= 1'b1;
                        if (!wr_q) dout_q <= in_range ? mem[idx] : '0;
`ifdef DMEM_ERR_EN
                        err_q   <= !in_range;
`endif
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
`ifdef DMEM_ERR_EN
                    err_q   <= 1'b0;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.dout = dout_q;
    assign bus.ack  = ack_q;
    assign bus.busy = busy_q;
endmodule
